// File: rtl/nn_mem_pkg.sv
// Shared constants for the neural-net parameter memory: loader FSM encoding,
// BRAM map and platform read latency.
package nn_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } loader_state_e;

  localparam int BIAS_L1_BASE    = 1024;
  localparam int WEIGHT_L1_BASE  = 0;
  localparam int BRAM_RD_LATENCY = 2;

endpackage

// File: rtl/valid_delay_pipe.sv
// 1-bit shift register that delays a read strobe by DEPTH cycles so it lines
// up with the matching BRAM read data.
module valid_delay_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_param_loader.sv
// Burst loader: reads COUNT consecutive words from a BRAM starting at a runtime
// base address and presents them as one flat vector (word 0 at the LSBs).
module bram_param_loader
  import nn_mem_pkg::*;
#(
  parameter int W          = 8,
  parameter int COUNT      = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = BRAM_RD_LATENCY,
  parameter int CNT_W      = $clog2(COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [W-1:0]          bram_dout,
  output logic [COUNT*W-1:0]    data_out,
  output logic                  busy,
  output logic                  done
);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic                  en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]      issue_q, issue_d, cap_q, cap_d;
  logic [COUNT*W-1:0]    data_q, data_d;
  logic                  rd_vld;

  valid_delay_pipe #(.DEPTH(RD_LATENCY)) u_vld_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (en_q),
    .dout (rd_vld)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = done_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    data_d  = data_q;

    // Capture is independent of state: late data from ISSUE overlaps new issues.
    if (rd_vld) begin
      data_d[int'(cap_q)*W +: W] = bram_dout;
      cap_d = cap_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ISSUE;
          base_d  = base_addr;
          addr_d  = base_addr;
          en_d    = 1'b1;
          issue_d = CNT_W'(1);
          cap_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (issue_q == CNT_W'(COUNT)) begin
          en_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d  = base_q + ADDR_WIDTH'(issue_q);
          issue_d = issue_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (rd_vld && cap_q == CNT_W'(COUNT - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= '0;
      cap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
    end
  end

  assign bram_en   = en_q;
  assign bram_addr = addr_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
